display_mux_ctrl: RTL

Time-multiplexing scheduler for the dual seven-segment display. It shares the single 4-bit 2:1 digit mux and seven-segment decoder between two digits. It produces the mux select, the active-low anode enables and double-buffered digit values, and inserts a blanking dead-time around every select change so that no digit ghosts onto the other. It sits between the keypad/digit-history logic and the mux-plus-decoder path.

---
 rtl/display_mux_ctrl_if.sv | 22 ++
 rtl/display_mux_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/display_mux_ctrl_if.sv
// Digit/handshake bundle between the keypad history logic, the scheduler and the mux/decoder path.
interface display_mux_ctrl_if;
    logic [3:0] digit0_in;
    logic [3:0] digit1_in;
    logic       load;
    logic       blank_req;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       select;
    logic [1:0] anode;
    logic       frame_tick;

    modport master (
        output digit0_in, digit1_in, load, blank_req,
        input  d0, d1, select, anode, frame_tick
    );

    modport slave (
        input  digit0_in, digit1_in, load, blank_req,
        output d0, d1, select, anode, frame_tick
    );
endinterface

// File: rtl/display_mux_ctrl.sv
// Two-digit seven-segment time-multiplex scheduler with blanking dead-time
// and frame-synchronous double-buffered digit values.
module display_mux_ctrl #(
    parameter int DIGIT_CYCLES = 20000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic               clk,
    input  logic               reset,
    display_mux_ctrl_if.slave  bus
);
    localparam int MAXC  = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [1:0] SHOW0  = 2'd0;
    localparam logic [1:0] BLANK0 = 2'd1;
    localparam logic [1:0] SHOW1  = 2'd2;
    localparam logic [1:0] BLANK1 = 2'd3;

    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       stage0, stage1;
    logic [3:0]       d0_r, d1_r;
    logic             pending;
    logic             ft_r;
    logic             last;
    logic             boundary;

    always_comb begin
        last = 1'b0;
        if (state == SHOW0 || state == SHOW1)
            last = (cnt == DIG_LAST);
        else
            last = (cnt == BLK_LAST);
        boundary = (state == BLANK1) && last;
    end

    // State order is encoded so that advancing by one walks the frame and wraps to SHOW0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BLANK1;
            cnt     <= '0;
            ft_r    <= 1'b0;
            d0_r    <= 4'd0;
            d1_r    <= 4'd0;
            stage0  <= 4'd0;
            stage1  <= 4'd0;
            pending <= 1'b0;
        end else begin
            if (last) begin
                state <= state + 2'd1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            ft_r <= boundary;

            if (bus.load) begin
                stage0 <= bus.digit0_in;
                stage1 <= bus.digit1_in;
            end

            // A load landing on the boundary edge bypasses the stage registers.
            if (boundary) begin
                if (bus.load) begin
                    d0_r <= bus.digit0_in;
                    d1_r <= bus.digit1_in;
                end else if (pending) begin
                    d0_r <= stage0;
                    d1_r <= stage1;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.anode = 2'b11;
        case (state)
            SHOW0:   bus.anode = 2'b10;
            SHOW1:   bus.anode = 2'b01;
            default: bus.anode = 2'b11;
        endcase
        if (bus.blank_req)
            bus.anode = 2'b11;
    end

    assign bus.select     = (state == BLANK0) || (state == SHOW1);
    assign bus.d0         = d0_r;
    assign bus.d1         = d1_r;
    assign bus.frame_tick = ft_r;
endmodule
